// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX feeder: FSM state encoding and pointer-width helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_ACK  = 2'b01,
    WAIT_DONE = 2'b10
  } tx_state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  // One extra MSB beyond the address lets full and empty be told apart when the pointers alias.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = $clog2(FIFO_DEPTH_DEF) + 1;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Write-side and transmitter-side signals of uart_tx_feeder.
// UART_TX_FEEDER_OVF_EN adds the sticky OVERFLOW flag.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = ptr_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_EN;
  logic                  FULL;
  logic                  EMPTY;
  logic [CW-1:0]         COUNT;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_BUSY;
`ifdef UART_TX_FEEDER_OVF_EN
  logic                  OVERFLOW;
`endif

  modport master (
    output WR_DATA, WR_EN, TX_BUSY,
    input  FULL, EMPTY, COUNT, TX_P_DATA, TX_D_VLD
`ifdef UART_TX_FEEDER_OVF_EN
    , input OVERFLOW
`endif
  );

  modport slave (
    input  WR_DATA, WR_EN, TX_BUSY,
    output FULL, EMPTY, COUNT, TX_P_DATA, TX_D_VLD
`ifdef UART_TX_FEEDER_OVF_EN
    , output OVERFLOW
`endif
  );

endinterface

// File: rtl/tx_sync_fifo.sv
// Synchronous byte FIFO feeding the UART TX dispatcher; pop is driven by the dispatcher FSM.
// UART_TX_FEEDER_OVF_EN adds a sticky flag for writes dropped while full.
module tx_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int PW         = ptr_width(FIFO_DEPTH),
  localparam int AW         = PW - 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PW-1:0]         count_o
`ifdef UART_TX_FEEDER_OVF_EN
  , output logic                ovf_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  wr_fire, rd_fire;

  // Flags come straight from the registered pointers, so a same-cycle pop never unblocks a write.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (wr_en_i && full_o);
  assign ovf_o = ovf_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system-side bytes and hands them one at a time to the UART transmitter, paced on TX_BUSY.
// UART_TX_FEEDER_OVF_EN enables the OVERFLOW output.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic              CLK,
  input logic              RST,
  uart_tx_feeder_if.slave  bus
);

  localparam int CW = ptr_width(FIFO_DEPTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  full, empty;
  logic [CW-1:0]         count;

  tx_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_data_i(bus.WR_DATA),
    .wr_en_i  (bus.WR_EN),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count)
`ifdef UART_TX_FEEDER_OVF_EN
    , .ovf_o  (bus.OVERFLOW)
`endif
  );

  // Launch only from IDLE with the line free; WAIT_DONE guarantees one launch per BUSY pulse.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.TX_BUSY) begin
          data_d  = head;
          pop     = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (bus.TX_BUSY)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.TX_BUSY) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign bus.TX_D_VLD  = (state_q == WAIT_ACK);
  assign bus.TX_P_DATA = data_q;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.COUNT     = count;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: occupancy/launch model, transmitter model and directed scenarios.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FRAME = 10;

  logic CLK = 1'b0;
  logic RST;
  logic force_busy;
  logic xmt_busy = 1'b0;
  int   xmt_cnt  = 0;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.TX_BUSY = force_busy | xmt_busy;

  int errors = 0;
  int checks = 0;

  // Transmitter: accepts a byte when idle and valid is high, then stays busy for FRAME cycles.
  logic [DW-1:0] rx[$];
  always @(posedge CLK) begin
    if (xmt_busy) begin
      if (xmt_cnt <= 1) xmt_busy <= 1'b0;
      else              xmt_cnt  <= xmt_cnt - 1;
    end else if (bus.TX_D_VLD && !force_busy) begin
      rx.push_back(bus.TX_P_DATA);
      xmt_busy <= 1'b1;
      xmt_cnt  <= FRAME;
    end
  end

  // Feeder model: a byte queue plus "presenting" / "frame in flight" phases.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data  = '0;
  bit            m_present = 1'b0;
  bit            m_frame   = 1'b0;
  bit            m_ovf     = 1'b0;
  bit            m_go, m_busy, m_wr;
  int            m_n;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q.delete();
      m_data    = '0;
      m_present = 1'b0;
      m_frame   = 1'b0;
      m_ovf     = 1'b0;
    end else begin
      m_busy = bus.TX_BUSY;
      m_wr   = bus.WR_EN;
      m_n    = m_q.size();
      m_go   = !m_present && !m_frame && (m_n > 0) && !m_busy;
      if (m_present && m_busy) begin
        m_present = 1'b0;
        m_frame   = 1'b1;
      end else if (m_frame && !m_busy) begin
        m_frame = 1'b0;
      end
      if (m_wr && m_n == DEPTH) m_ovf = 1'b1;
      if (m_go) begin
        m_data    = m_q.pop_front();
        m_present = 1'b1;
      end
      if (m_wr && m_n < DEPTH) m_q.push_back(bus.WR_DATA);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_checker();
    forever begin
      @(negedge CLK);
      chk("count", int'(bus.COUNT), m_q.size());
      chk("full", int'(bus.FULL), int'(m_q.size() == DEPTH));
      chk("empty", int'(bus.EMPTY), int'(m_q.size() == 0));
      chk("d_vld", int'(bus.TX_D_VLD), int'(m_present));
      chk("p_data", int'(bus.TX_P_DATA), int'(m_data));
`ifdef UART_TX_FEEDER_OVF_EN
      chk("overflow", int'(bus.OVERFLOW), int'(m_ovf));
`endif
    end
  endtask

  // Called at posedge+2; returns at the following posedge+2 with the byte written on that edge.
  task automatic wr_byte(input logic [DW-1:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    @(posedge CLK);
    #2;
    bus.WR_EN = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    for (int i = 0; i < 600 && rx.size() < n; i++) @(posedge CLK);
    chk(name, rx.size(), n);
    repeat (FRAME + 4) @(posedge CLK);
    #2;
  endtask

  int base;
  int vcnt;
  int bad;

  initial begin
    RST         = 1'b1;
    force_busy  = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    fork
      cycle_checker();
    join_none

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_count", int'(bus.COUNT), 0);
    chk("rst_empty", int'(bus.EMPTY), 1);
    chk("rst_full", int'(bus.FULL), 0);
    chk("rst_vld", int'(bus.TX_D_VLD), 0);
    chk("rst_data", int'(bus.TX_P_DATA), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Idle with empty FIFO
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.TX_D_VLD) vcnt++;
    end
    chk("idle_vld", vcnt, 0);
    @(posedge CLK);
    #2;

    // Single byte
    base = rx.size();
    wr_byte(8'hA5);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (bus.TX_D_VLD) vcnt++;
      if (i == 0) begin
        chk("single_empty_n", int'(bus.EMPTY), 0);
        chk("single_count_n", int'(bus.COUNT), 1);
      end
      if (i == 1) begin
        chk("single_vld_n1", int'(bus.TX_D_VLD), 1);
        chk("single_data_n1", int'(bus.TX_P_DATA), 8'hA5);
      end
    end
    chk("single_vld_width", vcnt, 2);
    wait_rx(base + 1, "single_frames");
    chk("single_rx", int'(rx[base]), 8'hA5);
    chk("single_one_frame", rx.size(), base + 1);

    // Burst 0x01..0x08
    base = rx.size();
    for (int d = 1; d <= 8; d++) wr_byte(DW'(d));
    @(negedge CLK);
    chk("burst_count", int'(bus.COUNT), 7);
    chk("burst_full", int'(bus.FULL), 0);
    @(posedge CLK);
    #2;
    wait_rx(base + 8, "burst_frames");
    for (int i = 0; i < 8; i++) chk("burst_order", int'(rx[base+i]), i + 1);

    // Overflow with transmitter held busy
    force_busy = 1'b1;
    @(posedge CLK);
    #2;
    base = rx.size();
    for (int d = 0; d < 9; d++) wr_byte(DW'(8'h10 + d));
    @(negedge CLK);
    chk("ovf_count", int'(bus.COUNT), 8);
    chk("ovf_full", int'(bus.FULL), 1);
    chk("ovf_vld", int'(bus.TX_D_VLD), 0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf_flag", int'(bus.OVERFLOW), 1);
`endif
    @(posedge CLK);
    #2;
    force_busy = 1'b0;
    wait_rx(base + 8, "ovf_frames");
    for (int i = 0; i < 8; i++) chk("ovf_order", int'(rx[base+i]), 8'h10 + i);

    // Write on the launch edge with COUNT = 3
    force_busy = 1'b1;
    @(posedge CLK);
    #2;
    base = rx.size();
    wr_byte(8'h20);
    wr_byte(8'h21);
    wr_byte(8'h22);
    force_busy  = 1'b0;
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'h23;
    @(posedge CLK);
    #2;
    bus.WR_EN = 1'b0;
    @(negedge CLK);
    chk("simul_count", int'(bus.COUNT), 3);
    chk("simul_vld", int'(bus.TX_D_VLD), 1);
    chk("simul_data", int'(bus.TX_P_DATA), 8'h20);
    @(posedge CLK);
    #2;
    wait_rx(base + 4, "simul_frames");
    for (int i = 0; i < 4; i++) chk("simul_order", int'(rx[base+i]), 8'h20 + i);

    // Reset mid-frame in WAIT_DONE with COUNT = 4
    base = rx.size();
    for (int d = 0; d < 5; d++) wr_byte(DW'(8'h30 + d));
    @(negedge CLK);
    chk("midrst_count_pre", int'(bus.COUNT), 4);
    chk("midrst_busy_pre", int'(bus.TX_BUSY), 1);
    chk("midrst_vld_pre", int'(bus.TX_D_VLD), 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_empty", int'(bus.EMPTY), 1);
    chk("midrst_count", int'(bus.COUNT), 0);
    chk("midrst_vld", int'(bus.TX_D_VLD), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    wr_byte(8'h40);
    bad = 0;
    for (int i = 0; i < 30 && bus.TX_BUSY; i++) begin
      @(negedge CLK);
      if (bus.TX_BUSY && bus.TX_D_VLD) bad++;
    end
    chk("midrst_no_launch_busy", bad, 0);
    chk("midrst_busy_released", int'(bus.TX_BUSY), 0);
    @(posedge CLK);
    #2;
    wait_rx(base + 2, "midrst_frames");
    chk("midrst_inflight", int'(rx[base]), 8'h30);
    chk("midrst_after", int'(rx[base+1]), 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
